// File: rtl/tile_seq_p.sv
// Tile sequencer for an ARR x ARR MAC array: walks t (innermost), m, then n tiles,
// issuing operand load beats, a compute window, drain wait and accumulate write-back.
module tile_seq_p #(
   parameter int ARR    = 4,
   parameter int DIM_W  = 5,
   parameter int DATA_W = 8,
   localparam int LOG_ARR = $clog2(ARR),
   localparam int TW      = DIM_W - LOG_ARR,
   localparam int AW      = 2*TW + LOG_ARR,
   localparam int SH_W    = $clog2(ARR*DATA_W+1)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               Start,
   input  logic [3*DIM_W-1:0] MNT,
   input  logic               Stall,
   input  logic               Tile_Done,
   input  logic               STORE_ACK,
   output logic               BUSY,
   output logic               DONE,
   output logic               ERR,
   output logic               LOAD_I,
   output logic               LOAD_W,
   output logic [LOG_ARR-1:0] IROW,
   output logic [LOG_ARR-1:0] WROW,
   output logic [AW-1:0]      ADDR_I,
   output logic [AW-1:0]      ADDR_W,
   output logic [AW-1:0]      ODST,
   output logic               START_CALC,
   output logic               ACC,
   output logic               STORE_REQ,
   output logic [LOG_ARR:0]   ROW_TOTAL,
   output logic [TW-1:0]      T_IDX,
   output logic [TW-1:0]      M_IDX,
   output logic [TW-1:0]      N_IDX,
   output logic [SH_W-1:0]    SHAMT,
   output logic               CLR_DP,
   output logic               CLR_W
);

   typedef enum logic [2:0] {
      IDLE, LOAD_BOTH, LOAD_IN, RUN, DRAIN, STORE, BRANCH
   } state_t;

   state_t             state_q, state_d;
   logic [DIM_W-1:0]   m_q, n_q, t_q;
   logic [TW-1:0]      t_idx_q, m_idx_q, n_idx_q;
   logic [LOG_ARR:0]   icnt_q, wcnt_q, i_nxt, w_nxt;
   logic [LOG_ARR-1:0] rcnt_q;
   logic [LOG_ARR:0]   rem_t_q, rem_m_q;
   logic [SH_W-1:0]    shamt_q;
   logic               acc_q, last_q;
   logic               done_q, err_q, clr_dp_q, clr_w_q;
   logic               load_i, load_w, start_ok, start_bad, enter_branch;
   logic               t_wrap, m_wrap, n_wrap;
   logic [DIM_W-1:0]   mnt_m, mnt_n, mnt_t;

   assign mnt_m = MNT[3*DIM_W-1:2*DIM_W];
   assign mnt_n = MNT[2*DIM_W-1:DIM_W];
   assign mnt_t = MNT[DIM_W-1:0];

   // Rows left in a dimension at tile idx, clipped to the array edge.
   function automatic logic [LOG_ARR:0] rem_of(input logic [DIM_W-1:0] x,
                                                input logic [TW-1:0]    idx);
      logic [DIM_W-1:0] left;
      left = x - {idx, {LOG_ARR{1'b0}}};
      if (left >= DIM_W'(ARR)) rem_of = (LOG_ARR+1)'(ARR);
      else                     rem_of = (LOG_ARR+1)'(left);
   endfunction

   function automatic logic [TW-1:0] last_idx(input logic [DIM_W-1:0] x);
      last_idx = TW'((x - DIM_W'(1)) >> LOG_ARR);
   endfunction

   function automatic logic [SH_W-1:0] shamt_of(input logic [LOG_ARR:0] rem);
      shamt_of = SH_W'((ARR - int'(rem)) * DATA_W);
   endfunction

   assign t_wrap = (t_idx_q == last_idx(t_q));
   assign m_wrap = (m_idx_q == last_idx(m_q));
   assign n_wrap = (n_idx_q == last_idx(n_q));

   always_comb begin
      state_d   = state_q;
      load_i    = 1'b0;
      load_w    = 1'b0;
      start_ok  = 1'b0;
      start_bad = 1'b0;
      i_nxt     = icnt_q;
      w_nxt     = wcnt_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               if ((mnt_m == '0) || (mnt_n == '0) || (mnt_t == '0)) begin
                  start_bad = 1'b1;
               end else begin
                  start_ok = 1'b1;
                  state_d  = LOAD_BOTH;
               end
            end
         end
         LOAD_BOTH: begin
            load_i = (icnt_q < rem_t_q) && !Stall;
            load_w = (wcnt_q < rem_m_q) && !Stall;
            i_nxt  = icnt_q + {{LOG_ARR{1'b0}}, load_i};
            w_nxt  = wcnt_q + {{LOG_ARR{1'b0}}, load_w};
            if ((i_nxt == rem_t_q) && (w_nxt == rem_m_q)) state_d = RUN;
         end
         LOAD_IN: begin
            load_i = (icnt_q < rem_t_q) && !Stall;
            i_nxt  = icnt_q + {{LOG_ARR{1'b0}}, load_i};
            if (i_nxt == rem_t_q) state_d = RUN;
         end
         RUN: begin
            if (rcnt_q == LOG_ARR'(ARR-1)) state_d = DRAIN;
         end
         DRAIN: begin
            if (Tile_Done) state_d = acc_q ? STORE : BRANCH;
         end
         STORE: begin
            if (STORE_ACK) state_d = BRANCH;
         end
         BRANCH: begin
            if (last_q)                state_d = IDLE;
            else if (t_idx_q != '0)    state_d = LOAD_IN;
            else                       state_d = LOAD_BOTH;
         end
         default: state_d = IDLE;
      endcase
   end

   assign enter_branch = (state_d == BRANCH) && (state_q != BRANCH);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         m_q      <= '0;
         n_q      <= '0;
         t_q      <= '0;
         t_idx_q  <= '0;
         m_idx_q  <= '0;
         n_idx_q  <= '0;
         icnt_q   <= '0;
         wcnt_q   <= '0;
         rcnt_q   <= '0;
         rem_t_q  <= '0;
         rem_m_q  <= '0;
         shamt_q  <= '0;
         acc_q    <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         clr_dp_q <= 1'b0;
         clr_w_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         done_q   <= 1'b0;
         err_q    <= start_bad;
         clr_dp_q <= 1'b0;
         clr_w_q  <= 1'b0;

         if (start_ok) begin
            m_q     <= mnt_m;
            n_q     <= mnt_n;
            t_q     <= mnt_t;
            t_idx_q <= '0;
            m_idx_q <= '0;
            n_idx_q <= '0;
            icnt_q  <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            last_q  <= 1'b0;
            rem_t_q <= rem_of(mnt_t, '0);
            rem_m_q <= rem_of(mnt_m, '0);
            shamt_q <= shamt_of(rem_of(mnt_n, '0));
            acc_q   <= 1'b0;
         end

         // Load beat counters restart for the next tile as soon as RUN is entered.
         if ((state_q == LOAD_BOTH) || (state_q == LOAD_IN)) begin
            if (state_d == RUN) begin
               icnt_q <= '0;
               wcnt_q <= '0;
            end else begin
               icnt_q <= i_nxt;
               wcnt_q <= w_nxt;
            end
         end

         if (state_q == RUN) rcnt_q <= rcnt_q + LOG_ARR'(1);

         if (enter_branch) begin
            last_q <= t_wrap && m_wrap && n_wrap;
            if (!t_wrap) begin
               t_idx_q <= t_idx_q + TW'(1);
            end else begin
               t_idx_q <= '0;
               if (!m_wrap) begin
                  m_idx_q <= m_idx_q + TW'(1);
               end else begin
                  m_idx_q <= '0;
                  n_idx_q <= n_wrap ? '0 : n_idx_q + TW'(1);
               end
            end
         end

         // Pointers already advanced here, so the tile geometry is for the next tile.
         if (state_q == BRANCH) begin
            rem_t_q  <= rem_of(t_q, t_idx_q);
            rem_m_q  <= rem_of(m_q, m_idx_q);
            shamt_q  <= shamt_of(rem_of(n_q, n_idx_q));
            acc_q    <= (n_idx_q != '0);
            clr_dp_q <= 1'b1;
            if (last_q) begin
               done_q  <= 1'b1;
               clr_w_q <= 1'b1;
            end else if (t_idx_q == '0) begin
               clr_w_q <= 1'b1;
            end
         end
      end
   end

   assign BUSY       = (state_q != IDLE);
   assign DONE       = done_q;
   assign ERR        = err_q;
   assign LOAD_I     = load_i;
   assign LOAD_W     = load_w;
   assign IROW       = icnt_q[LOG_ARR-1:0];
   assign WROW       = wcnt_q[LOG_ARR-1:0];
   assign ADDR_I     = {n_idx_q, t_idx_q, icnt_q[LOG_ARR-1:0]};
   assign ADDR_W     = {n_idx_q, m_idx_q, wcnt_q[LOG_ARR-1:0]};
   assign ODST       = {m_idx_q, t_idx_q, icnt_q[LOG_ARR-1:0]};
   assign START_CALC = (state_q == RUN);
   assign ACC        = acc_q;
   assign STORE_REQ  = (state_q == STORE);
   assign ROW_TOTAL  = rem_t_q;
   assign T_IDX      = t_idx_q;
   assign M_IDX      = m_idx_q;
   assign N_IDX      = n_idx_q;
   assign SHAMT      = shamt_q;
   assign CLR_DP     = clr_dp_q;
   assign CLR_W      = clr_w_q;

endmodule

// File: tb/tb_tile_seq_p.sv
// Directed bench for tile_seq_p with ARR=4, DIM_W=5, DATA_W=8.
module tb_tile_seq_p;
   localparam int ARR = 4, DIM_W = 5, DATA_W = 8, TW = 3, AW = 8, SH_W = 6;

   logic CLK = 1'b0, RST = 1'b1, Start = 1'b0, Stall = 1'b0;
   logic Tile_Done = 1'b0, STORE_ACK = 1'b0;
   logic [3*DIM_W-1:0] MNT = '0;
   logic BUSY, DONE, ERR, LOAD_I, LOAD_W, START_CALC, ACC, STORE_REQ, CLR_DP, CLR_W;
   logic [1:0] IROW, WROW;
   logic [AW-1:0] ADDR_I, ADDR_W, ODST;
   logic [2:0] ROW_TOTAL;
   logic [TW-1:0] T_IDX, M_IDX, N_IDX;
   logic [SH_W-1:0] SHAMT;

   int checks = 0, errors = 0;
   int ni, nw, ncw, ncd, ncalc, nst, smax, ndone, nerr, tiles;
   int rt[8], tf[8], mi[8], ac[8], sh[8];

   tile_seq_p #(.ARR(ARR), .DIM_W(DIM_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .MNT(MNT), .Stall(Stall),
      .Tile_Done(Tile_Done), .STORE_ACK(STORE_ACK), .BUSY(BUSY), .DONE(DONE),
      .ERR(ERR), .LOAD_I(LOAD_I), .LOAD_W(LOAD_W), .IROW(IROW), .WROW(WROW),
      .ADDR_I(ADDR_I), .ADDR_W(ADDR_W), .ODST(ODST), .START_CALC(START_CALC),
      .ACC(ACC), .STORE_REQ(STORE_REQ), .ROW_TOTAL(ROW_TOTAL), .T_IDX(T_IDX),
      .M_IDX(M_IDX), .N_IDX(N_IDX), .SHAMT(SHAMT), .CLR_DP(CLR_DP), .CLR_W(CLR_W)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [14:0] dims(input int m, input int n, input int t);
      dims = {5'(m), 5'(n), 5'(t)};
   endfunction

   // Free-runs a sequence to DONE with Tile_Done held high and STORE_ACK given on
   // the third STORE_REQ cycle, tallying beats, pulses and per-tile first-beat state.
   task automatic track(input int budget);
      int srun;
      bit seen;
      ni = 0; nw = 0; ncw = 0; ncd = 0; ncalc = 0; nst = 0; smax = 0;
      ndone = 0; nerr = 0; tiles = 0; srun = 0; seen = 0;
      Tile_Done = 1'b1;
      for (int c = 0; c < budget && !seen; c++) begin
         if (LOAD_I) begin
            ni++;
            if (IROW == 2'd0 && tiles < 8) begin
               rt[tiles] = int'(ROW_TOTAL);
               tf[tiles] = int'(ODST[4:2]);
               mi[tiles] = int'(M_IDX);
               ac[tiles] = int'(ACC);
               sh[tiles] = int'(SHAMT);
               tiles++;
            end
         end
         if (LOAD_W) nw++;
         if (CLR_W) ncw++;
         if (CLR_DP) ncd++;
         if (START_CALC) ncalc++;
         if (ERR) nerr++;
         if (STORE_REQ) begin
            srun++;
            if (srun == 1) nst++;
            if (srun > smax) smax = srun;
            STORE_ACK = (srun >= 3);
         end else begin
            srun = 0;
            STORE_ACK = 1'b0;
         end
         if (DONE) begin
            ndone++;
            seen = 1;
         end else begin
            adv();
            #1;
         end
      end
      Tile_Done = 1'b0;
      STORE_ACK = 1'b0;
      chk("done_reached", 32'(seen), 1);
   endtask

   initial begin
      bit found;
      repeat (3) adv();
      RST = 1'b0;
      #1;
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_err", ERR, 0);
      chk("rst_load_i", LOAD_I, 0);
      chk("rst_row_total", ROW_TOTAL, 0);
      chk("rst_shamt", SHAMT, 0);
      chk("rst_odst", ODST, 0);
      chk("rst_clr_w", CLR_W, 0);

      // 4x4x4, single tile, no stall
      Start = 1'b1; MNT = dims(4, 4, 4);
      adv(); Start = 1'b0; #1;
      for (int c = 1; c <= 4; c++) begin
         chk("a_load_i", LOAD_I, 1);
         chk("a_load_w", LOAD_W, 1);
         chk("a_irow", IROW, c - 1);
         chk("a_wrow", WROW, c - 1);
         if (c == 1) begin
            chk("a_row_total", ROW_TOTAL, 4);
            chk("a_acc", ACC, 0);
         end
         adv(); #1;
      end
      for (int c = 5; c <= 8; c++) begin
         chk("a_calc", START_CALC, 1);
         chk("a_calc_noload", LOAD_I, 0);
         adv(); #1;
      end
      chk("a_drain_calc", START_CALC, 0);
      chk("a_drain_busy", BUSY, 1);
      chk("a_no_store", STORE_REQ, 0);
      Tile_Done = 1'b1;
      adv(); Tile_Done = 1'b0; #1;
      chk("a_branch_busy", BUSY, 1);
      chk("a_branch_done", DONE, 0);
      adv(); #1;
      chk("a_done", DONE, 1);
      chk("a_done_busy", BUSY, 0);
      chk("a_done_clr_dp", CLR_DP, 1);
      chk("a_done_clr_w", CLR_W, 1);
      chk("a_done_err", ERR, 0);
      adv(); #1;
      chk("a_done_pulse", DONE, 0);

      // Illegal dimension
      Start = 1'b1; MNT = dims(4, 4, 0);
      adv(); Start = 1'b0; #1;
      chk("e_err", ERR, 1);
      chk("e_busy", BUSY, 0);
      chk("e_load", LOAD_I, 0);
      adv(); #1;
      chk("e_err_pulse", ERR, 0);
      chk("e_busy2", BUSY, 0);

      // Reset wins over Start
      Start = 1'b1; MNT = dims(4, 4, 4); RST = 1'b1;
      adv(); Start = 1'b0; RST = 1'b0; #1;
      chk("rs_busy", BUSY, 0);

      // T=9: three t-tiles
      Start = 1'b1; MNT = dims(4, 4, 9);
      adv(); Start = 1'b0; #1;
      track(300);
      chk("t9_tiles", tiles, 3);
      chk("t9_ni", ni, 9);
      chk("t9_nw", nw, 4);
      chk("t9_clr_w", ncw, 1);
      chk("t9_clr_dp", ncd, 3);
      chk("t9_calc", ncalc, 12);
      chk("t9_store", nst, 0);
      chk("t9_err", nerr, 0);
      chk("t9_rt0", rt[0], 4);
      chk("t9_rt1", rt[1], 4);
      chk("t9_rt2", rt[2], 1);
      chk("t9_tf0", tf[0], 0);
      chk("t9_tf1", tf[1], 1);
      chk("t9_tf2", tf[2], 2);
      adv(); #1;
      chk("t9_idle", BUSY, 0);

      // N=6: second n-slab accumulates
      Start = 1'b1; MNT = dims(4, 6, 4);
      adv(); Start = 1'b0; #1;
      track(300);
      chk("n6_tiles", tiles, 2);
      chk("n6_ni", ni, 8);
      chk("n6_nw", nw, 8);
      chk("n6_clr_w", ncw, 2);
      chk("n6_store", nst, 1);
      chk("n6_store_len", smax, 3);
      chk("n6_acc0", ac[0], 0);
      chk("n6_acc1", ac[1], 1);
      chk("n6_sh0", sh[0], 0);
      chk("n6_sh1", sh[1], 16);
      chk("n6_done", ndone, 1);

      // Stall after the second beat, plus a Start while busy
      adv(); #1;
      Start = 1'b1; MNT = dims(4, 4, 4);
      adv(); Start = 1'b0; #1;
      chk("s_beat0", LOAD_I, 1);
      adv(); #1;
      chk("s_beat1", IROW, 1);
      for (int c = 3; c <= 5; c++) begin
         adv(); Stall = 1'b1;
         if (c == 3) begin
            Start = 1'b1; MNT = dims(1, 1, 1);
         end else begin
            Start = 1'b0;
         end
         #1;
         chk("s_stall_i", LOAD_I, 0);
         chk("s_stall_w", LOAD_W, 0);
         chk("s_stall_calc", START_CALC, 0);
      end
      adv(); Stall = 1'b0; Start = 1'b0; #1;
      chk("s_resume_i", LOAD_I, 1);
      chk("s_resume_irow", IROW, 2);
      chk("s_resume_wrow", WROW, 2);
      chk("s_row_total", ROW_TOTAL, 4);
      adv(); #1;
      chk("s_last_irow", IROW, 3);
      chk("s_last_calc", START_CALC, 0);
      adv(); #1;
      chk("s_run", START_CALC, 1);
      track(100);
      chk("s_calc", ncalc, 4);
      chk("s_extra_beats", ni + nw, 0);
      chk("s_done", ndone, 1);

      // Reset in the second RUN cycle, then a full fresh run
      adv(); #1;
      Start = 1'b1; MNT = dims(8, 4, 8);
      adv(); Start = 1'b0; #1;
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (START_CALC) found = 1;
         else begin
            adv(); #1;
         end
      end
      chk("r_run_reached", 32'(found), 1);
      adv(); #1;
      chk("r_run2", START_CALC, 1);
      RST = 1'b1;
      adv(); RST = 1'b0; #1;
      chk("r_busy", BUSY, 0);
      chk("r_calc", START_CALC, 0);
      chk("r_done", DONE, 0);
      chk("r_row_total", ROW_TOTAL, 0);
      chk("r_tidx", T_IDX, 0);
      Start = 1'b1; MNT = dims(8, 4, 8);
      adv(); Start = 1'b0; #1;
      chk("r_first_tidx", T_IDX, 0);
      track(400);
      chk("r_tiles", tiles, 4);
      chk("r_ni", ni, 16);
      chk("r_nw", nw, 8);
      chk("r_clr_w", ncw, 2);
      chk("r_clr_dp", ncd, 4);
      chk("r_calc_cnt", ncalc, 16);
      chk("r_tf1", tf[1], 1);
      chk("r_tf2", tf[2], 0);
      chk("r_mi2", mi[2], 1);
      chk("r_mi3", mi[3], 1);
      chk("r_done_cnt", ndone, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
